// File: rtl/alu_cmd_frontend.sv
// Switch/button command front end for the 8-bit ALU: sync, debounce, one command per press.
// Optional AUTOREPEAT_EN re-issues a command while the button stays held.
module alu_cmd_frontend #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_raw,
    input  logic [15:0] sw_raw,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [3:0]  cmd_op,
    output logic [7:0]  cmd_data,
    output logic        btn_level,
    output logic        busy
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_REL
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        btn_meta_q;
    logic        btn_sync_q;
    logic [15:0] sw_meta_q;
    logic [15:0] sw_sync_q;
    logic [DB_W-1:0] db_cnt_q;
    logic        btn_level_q;
    logic        btn_prev_q;
    logic        press_evt;
    logic        load;
    logic        sw_unused;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= sw_raw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES back-to-back mismatches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_q    <= '0;
            btn_level_q <= 1'b0;
            btn_prev_q  <= 1'b0;
        end else begin
            btn_prev_q <= btn_level_q;
            if (btn_sync_q == btn_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_MAX) begin
                db_cnt_q    <= '0;
                btn_level_q <= ~btn_level_q;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign press_evt = btn_level_q & ~btn_prev_q;
    assign sw_unused = ^sw_sync_q[7:4];

`ifdef AUTOREPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_hit;

    assign rpt_hit = (rpt_cnt_q == RPT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt_q <= '0;
        end else if (state_q == WAIT_REL && btn_level_q && !rpt_hit) begin
            rpt_cnt_q <= rpt_cnt_q + 1'b1;
        end else begin
            rpt_cnt_q <= '0;
        end
    end
`else
    localparam int RPT_UNUSED = REPEAT_CYCLES;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press_evt) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!btn_level_q) begin
                    state_d = IDLE;
`ifdef AUTOREPEAT_EN
                end else if (rpt_hit) begin
                    load    = 1'b1;
                    state_d = ISSUE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Payload is captured only on entry to ISSUE, so it cannot move while offered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_op   <= '0;
            cmd_data <= '0;
        end else if (load) begin
            cmd_op   <= sw_sync_q[3:0];
            cmd_data <= sw_sync_q[15:8];
        end
    end

    assign cmd_valid = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign btn_level = btn_level_q;

endmodule

// File: tb/tb_alu_cmd_frontend.sv
// Scoreboard bench for alu_cmd_frontend with short debounce/repeat settings.
// Define AUTOREPEAT_EN for both bench and RTL to exercise the repeat build.
module tb_alu_cmd_frontend;

    localparam int DB = 4;
    localparam int RP = 8;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] data;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_raw = 1'b0;
    logic [15:0] sw_raw = '0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        btn_level;
    logic        busy;

    cmd_t sb[$];
    int   xfer_cyc[$];
    int   n_xfer = 0;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    alu_cmd_frontend #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES(RP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_raw(btn_raw),
        .sw_raw(sw_raw),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_data(cmd_data),
        .btn_level(btn_level),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_cmd(input logic [3:0] op, input logic [7:0] data);
        cmd_t c;
        c.op   = op;
        c.data = data;
        sb.push_back(c);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [15:0] sw, input int hi, input int lo);
        sw_raw  = sw;
        btn_raw = 1'b1;
        tick(hi);
        btn_raw = 1'b0;
        tick(lo);
    endtask

    task automatic wait_valid(input int limit, output int lat);
        lat = 0;
        while (!cmd_valid && lat < limit) begin
            tick(1);
            lat++;
        end
    endtask

    // Monitor: every offered command must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && cmd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_cmd", {31'b0, cmd_valid}, 32'd0);
                if (cmd_ready) n_xfer++;
            end else begin
                check("cmd_op", {28'b0, cmd_op}, {28'b0, sb[0].op});
                check("cmd_data", {24'b0, cmd_data}, {24'b0, sb[0].data});
                if (cmd_ready) begin
                    void'(sb.pop_front());
                    n_xfer++;
                    xfer_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, checks);
        $fatal(1);
    end

    initial begin
        int base;
        int lat;

        tick(3);
        check("rst_valid", {31'b0, cmd_valid}, 32'd0);
        check("rst_op", {28'b0, cmd_op}, 32'd0);
        check("rst_data", {24'b0, cmd_data}, 32'd0);
        check("rst_level", {31'b0, btn_level}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // 1: single press, ready high; 2 sync + 4 debounce + 1 FSM cycle
        base      = n_xfer;
        cmd_ready = 1'b1;
        sw_raw    = 16'hA503;
        expect_cmd(4'h3, 8'hA5);
        btn_raw = 1'b1;
        wait_valid(20, lat);
        check("t1_latency", lat, 32'd7);
        tick(10 - lat);
        btn_raw = 1'b0;
        tick(20);
        check("t1_xfers", n_xfer - base, 32'd1);
        check("t1_sb_empty", sb.size(), 32'd0);

        // 2: glitch one cycle short of the debounce window
        base    = n_xfer;
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("t2_level", {31'b0, btn_level}, 32'd0);
        end
        check("t2_xfers", n_xfer - base, 32'd0);
        check("t2_busy", {31'b0, busy}, 32'd0);

        // 3: stalled consumer, switches change and button released mid-offer
        base      = n_xfer;
        cmd_ready = 1'b0;
        sw_raw    = 16'hA503;
        expect_cmd(4'h3, 8'hA5);
        btn_raw = 1'b1;
        tick(8);
        sw_raw = 16'h0000;
        tick(12);
        btn_raw = 1'b0;
        tick(10);
        check("t3_held_valid", {31'b0, cmd_valid}, 32'd1);
        check("t3_held_busy", {31'b0, busy}, 32'd1);
        cmd_ready = 1'b1;
        tick(3);
        check("t3_busy", {31'b0, busy}, 32'd0);
        check("t3_xfers", n_xfer - base, 32'd1);
        check("t3_sb_empty", sb.size(), 32'd0);

        // 4: two presses, in-order payloads
        base = n_xfer;
        expect_cmd(4'hE, 8'h7F);
        expect_cmd(4'hD, 8'h01);
        press(16'h7F0E, 10, 10);
        press(16'h010D, 10, 15);
        check("t4_xfers", n_xfer - base, 32'd2);
        check("t4_sb_empty", sb.size(), 32'd0);

        // 5: reset while offering discards the command
        base      = n_xfer;
        cmd_ready = 1'b0;
        sw_raw    = 16'h5C01;
        expect_cmd(4'h1, 8'h5C);
        btn_raw = 1'b1;
        wait_valid(20, lat);
        check("t5_valid", {31'b0, cmd_valid}, 32'd1);
        btn_raw = 1'b0;
        tick(1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'b0, cmd_valid}, 32'd0);
        check("t5_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        sb.delete();
        cmd_ready = 1'b1;
        tick(20);
        check("t5_no_replay", n_xfer - base, 32'd0);
        check("t5_idle", {31'b0, busy}, 32'd0);
        expect_cmd(4'h6, 8'h2B);
        press(16'h2B06, 10, 15);
        check("t5_fresh", n_xfer - base, 32'd1);
        check("t5_sb_empty", sb.size(), 32'd0);

        // 6: long hold
        base = n_xfer;
        xfer_cyc.delete();
`ifdef AUTOREPEAT_EN
        repeat (5) expect_cmd(4'h9, 8'h3C);
`else
        expect_cmd(4'h9, 8'h3C);
`endif
        press(16'h3C09, 40, 20);
`ifdef AUTOREPEAT_EN
        check("t6_xfers", n_xfer - base, 32'd5);
        if (xfer_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++)
                check("t6_period", xfer_cyc[i] - xfer_cyc[i-1], RP + 1);
        end
`else
        check("t6_xfers", n_xfer - base, 32'd1);
`endif
        check("t6_sb_empty", sb.size(), 32'd0);
        check("t6_busy", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
